// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// ----------------
// Elastic register chain used at every CPU stage boundary (IF/ID, ID/EX,
// EX/MEM, MEM/WB). It carries a WIDTH-bit bundle through STAGES stages using
// a valid/ready handshake. Each stage has a main register and a skid
// register, so the chain sustains one entry per cycle while its ready path
// stays fully registered. Stalls come from backpressure. Squashes come from
// the per-stage flush bits.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high reset
//   in_valid   upstream offers in_data
//   in_ready   chain accepts in_data this cycle (registered skid state only)
//   in_data    upstream entry
//   out_valid  last stage holds an entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   head entry (don't-care while out_valid is low)
//   flush      flush[i] clears both valid bits of stage i at this edge
//   count      registered number of live entries (0 .. 2*STAGES)
//   empty      count == 0
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    localparam int CW    = $clog2(2*STAGES+1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic [STAGES-1:0] flush,
    output logic [CW-1:0]     count,
    output logic              empty
);

    // Registered chain state
    logic [WIDTH-1:0]  main_data [STAGES];
    logic [WIDTH-1:0]  skid_data [STAGES];
    logic [STAGES-1:0] main_valid;
    logic [STAGES-1:0] skid_valid;
    logic [CW-1:0]     count_q;

    // Next-state values
    logic [WIDTH-1:0]  main_data_nxt [STAGES];
    logic [WIDTH-1:0]  skid_data_nxt [STAGES];
    logic [STAGES-1:0] main_valid_nxt;
    logic [STAGES-1:0] skid_valid_nxt;
    logic [CW-1:0]     count_nxt;

    // Per-stage handshake view
    logic [WIDTH-1:0]  up_data [STAGES];
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_ready;
    logic [STAGES-1:0] down_ready;
    logic [STAGES-1:0] accept;
    logic [STAGES-1:0] pop;

    // Wire each stage to its neighbours. A stage is ready while its skid is
    // free. That term is purely registered, so out_ready never reaches in_ready
    // combinationally.
    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_link
        if (g == 0) begin : g_head
            assign up_valid[g] = in_valid;
            assign up_data[g]  = in_data;
        end else begin : g_mid
            assign up_valid[g] = main_valid[g-1];
            assign up_data[g]  = main_data[g-1];
        end
        if (g == STAGES-1) begin : g_tail
            assign down_ready[g] = out_ready;
        end else begin : g_inner
            assign down_ready[g] = ~skid_valid[g+1];
        end
    end

    assign up_ready = ~skid_valid;
    assign accept   = up_valid & up_ready;
    assign pop      = down_ready & main_valid;

    // Per-stage update. A pop refills main from the skid first, because the
    // skid holds the older entry. An entry that arrives while main is held
    // goes into the skid. A flush clears both valid bits after the move, so
    // an entry arriving on the same edge is dropped. An entry leaving the
    // stage has already been handed to the next stage and is not affected.
    // The next count is the number of valid bits that survive the edge.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        count_nxt      = '0;
        for (int i = 0; i < STAGES; i++) begin
            main_data_nxt[i] = main_data[i];
            skid_data_nxt[i] = skid_data[i];
            if (pop[i]) begin
                if (skid_valid[i]) begin
                    main_data_nxt[i]  = skid_data[i];
                    skid_valid_nxt[i] = 1'b0;
                end else if (accept[i]) begin
                    main_data_nxt[i] = up_data[i];
                end else begin
                    main_valid_nxt[i] = 1'b0;
                end
            end else if (main_valid[i] && accept[i]) begin
                skid_data_nxt[i]  = up_data[i];
                skid_valid_nxt[i] = 1'b1;
            end else if (!main_valid[i] && accept[i]) begin
                main_data_nxt[i]  = up_data[i];
                main_valid_nxt[i] = 1'b1;
            end
            if (flush[i]) begin
                main_valid_nxt[i] = 1'b0;
                skid_valid_nxt[i] = 1'b0;
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            count_nxt = count_nxt + CW'(main_valid_nxt[i]) + CW'(skid_valid_nxt[i]);
        end
    end

    // State register. Reset clears the data registers as well as the valid
    // bits, so out_data reads zero after reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_valid <= '0;
            skid_valid <= '0;
            count_q    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                main_data[i] <= '0;
                skid_data[i] <= '0;
            end
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            count_q    <= count_nxt;
            for (int i = 0; i < STAGES; i++) begin
                main_data[i] <= main_data_nxt[i];
                skid_data[i] <= skid_data_nxt[i];
            end
        end
    end

    // in_ready is held low during Reset, so nothing offered then is accepted.
    assign in_ready  = up_ready[0] & ~Reset;
    assign out_valid = main_valid[STAGES-1];
    assign out_data  = main_data[STAGES-1];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain with WIDTH=32 and STAGES=4. A scoreboard
// queue gets every accepted entry that is not dropped. Each output handshake
// pops the queue and compares. count and empty are compared with the queue
// depth every cycle.
module tb_pipe_stage_chain;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  flush;
    logic [3:0]  count;
    logic        empty;

    pipe_stage_chain #(.WIDTH(32), .STAGES(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count),
        .empty     (empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    int first_acc = -1;
    int first_out = -1;
    int last_out = -1;

    // Single comparison point. It counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle. First check count/empty as left by the previous edge.
    // Then drive inputs and score both handshakes before the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                                 input logic [3:0] fl);
        @(negedge Clk);
        checkOutput("count", 32'(count), 32'(q.size()));
        checkOutput("empty", 32'(empty), 32'(q.size() == 0));
        Reset = 1'b0;
        in_valid = v;
        in_data = d;
        out_ready = rdy;
        flush = fl;
        #1;
        cyc++;
        if (out_valid && rdy) begin
            n_pop++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (q.size() == 0) checkOutput("spurious_out", 32'(out_valid), 32'd0);
            else checkOutput("out_data", out_data, q.pop_front());
        end
        if (v && in_ready) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            if (!fl[0]) q.push_back(d);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 4'b0000);
            n++;
        end
        checkOutput("drain_done", 32'(q.size()), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b0000);
    endtask

    initial begin
        int base_acc;
        int base_pop;
        int sent;
        int guard;
        logic v;
        logic r;
        logic [31:0] d;

        // Reset, with an entry offered that must never be accepted
        Reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h0000_1234;
        out_ready = 1'b1;
        flush = 4'b0000;
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("in_ready_during_reset", 32'(in_ready), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_in_ready_after", 32'(in_ready), 32'd1);

        // Stream 0x1..0x20 with out_ready high
        $display("[TB] stream");
        base_acc = n_acc;
        first_acc = -1;
        first_out = -1;
        for (int k = 1; k <= 32; k++) applyStimulus(1'b1, 32'(k), 1'b1, 4'b0000);
        drain();
        checkOutput("stream_accepts", 32'(n_acc - base_acc), 32'd32);
        checkOutput("stream_latency", 32'(first_out - first_acc), 32'd4);
        checkOutput("stream_no_bubble", 32'(last_out - first_out), 32'd31);

        // Fill with out_ready low, then release and keep offering
        $display("[TB] fill/backpressure");
        base_acc = n_acc;
        for (int k = 0; k < 12; k++)
            applyStimulus(1'b1, 32'hA0 + 32'(n_acc - base_acc), 1'b0, 4'b0000);
        checkOutput("fill_accepts", 32'(n_acc - base_acc), 32'd8);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        base_acc = n_acc;
        base_pop = n_pop;
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 32'hA8 + 32'(n_acc - base_acc), 1'b1, 4'b0000);
        checkOutput("release_pops", 32'(n_pop - base_pop), 32'd16);
        checkOutput("release_accepts", 32'(n_acc - base_acc), 32'd12);
        drain();

        // One entry per stage (B0 in stage 3 .. B3 in stage 0). flush[1]
        // with out_ready low: B2 leaves stage 1 and survives, and B3, moving
        // into stage 1, is killed.
        $display("[TB] flush mid-stage");
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'hB0 + 32'(k), 1'b0, 4'b0000);
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0010);
        q.delete(3);
        drain();

        // flush[0] while stage 0 forwards 0x51 and accepts 0x55
        $display("[TB] flush with transfer");
        applyStimulus(1'b1, 32'h50, 1'b1, 4'b0000);
        applyStimulus(1'b1, 32'h51, 1'b1, 4'b0000);
        base_acc = n_acc;
        applyStimulus(1'b1, 32'h55, 1'b1, 4'b0001);
        checkOutput("flush0_handshake", 32'(n_acc - base_acc), 32'd1);
        drain();

        // Full, frozen chain: flush[1] kills both stage-1 entries (C4, C5)
        $display("[TB] flush full chain");
        base_acc = n_acc;
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b1, 32'hC0 + 32'(n_acc - base_acc), 1'b0, 4'b0000);
        applyStimulus(1'b0, 32'd0, 1'b0, 4'b0010);
        q.delete(5);
        q.delete(4);
        drain();

        // Reset mid-operation on a full chain
        $display("[TB] reset mid-operation");
        base_acc = n_acc;
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b1, 32'hD0 + 32'(n_acc - base_acc), 1'b0, 4'b0000);
        @(negedge Clk);
        checkOutput("pre_reset_count", 32'(count), 32'd8);
        Reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        #1;
        checkOutput("in_ready_mid_reset", 32'(in_ready), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'd0, 1'b1, 4'b0000);

        // Random valid/ready at 50%
        $display("[TB] random");
        sent = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            base_acc = n_acc;
            applyStimulus(v, d, r, 4'b0000);
            if (n_acc != base_acc) sent++;
            guard++;
        end
        checkOutput("random_sent", 32'(sent), 32'd1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
